// File: rtl/custom_axi_ip_pkg.sv
// Shared types and constants for the custom_axi_ip register front end.
// status_e encoding is fixed because software reads it back raw from STATUS[1:0].
package custom_axi_ip_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } status_e;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   localparam logic [3:0] CTRL_OFS     = 4'h0;
   localparam logic [3:0] DATA_IN_OFS  = 4'h4;
   localparam logic [3:0] DATA_OUT_OFS = 4'h8;
   localparam logic [3:0] STATUS_OFS   = 4'hC;

   localparam int START       = 0;
   localparam int IRQ_EN      = 1;
   localparam int DONE_STICKY = 8;
   localparam int START_ERR   = 9;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Word select within the 16-byte register window; byte offset bits are ignored.
   function automatic logic [1:0] reg_sel(input logic [3:0] ofs);
      return ofs[3:2];
   endfunction

endpackage

// File: rtl/custom_axi_lite_if.sv
// AXI4-Lite channel handling: independent write and read FSMs that reduce the bus
// to a single-cycle wr_req / rd_req towards the register file.
module custom_axi_lite_if
   import custom_axi_ip_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic                    wr_req,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    wr_err,
   output logic                    rd_req,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    rd_err
);

   wr_state_e wr_state, wr_state_next;
   rd_state_e rd_state, rd_state_next;
   logic      aw_held, w_held;
   logic      ports_open;

   // Keeps every ready low while in reset and opens them the first cycle after.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ports_open <= 1'b0;
      else         ports_open <= 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wr_state <= W_IDLE;
      else         wr_state <= wr_state_next;
   end

   always_comb begin
      wr_state_next = wr_state;
      case (wr_state)
         W_IDLE:  if (aw_held && w_held) wr_state_next = W_RESP;
         W_RESP:  if (s_bready)          wr_state_next = W_IDLE;
         default: wr_state_next = W_IDLE;
      endcase
   end

   always_comb begin
      s_awready = ports_open && (wr_state == W_IDLE) && !aw_held;
      s_wready  = ports_open && (wr_state == W_IDLE) && !w_held;
      s_bvalid  = (wr_state == W_RESP);
      wr_req    = (wr_state == W_IDLE) && aw_held && w_held;
   end

   // AW and W are latched independently and released together by wr_req.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_strb <= '0;
         s_bresp <= RESP_OKAY;
      end else begin
         if (s_awvalid && s_awready) begin
            aw_held <= 1'b1;
            wr_addr <= s_awaddr;
         end else if (wr_req) begin
            aw_held <= 1'b0;
         end
         if (s_wvalid && s_wready) begin
            w_held  <= 1'b1;
            wr_data <= s_wdata;
            wr_strb <= s_wstrb;
         end else if (wr_req) begin
            w_held  <= 1'b0;
         end
         if (wr_req) s_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_state <= R_IDLE;
      else         rd_state <= rd_state_next;
   end

   always_comb begin
      rd_state_next = rd_state;
      case (rd_state)
         R_IDLE:  if (rd_req)   rd_state_next = R_DATA;
         R_DATA:  if (s_rready) rd_state_next = R_IDLE;
         default: rd_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      s_arready = ports_open && (rd_state == R_IDLE);
      s_rvalid  = (rd_state == R_DATA);
      rd_req    = s_arvalid && s_arready;
      rd_addr   = s_araddr;
   end

   // Read data is captured at the AR handshake and frozen until rready.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_rdata <= '0;
         s_rresp <= RESP_OKAY;
      end else if (rd_req) begin
         s_rdata <= rd_err ? '0 : rd_data;
         s_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

endmodule

// File: rtl/custom_axi_lite_regs.sv
// CPU-facing register file for custom_axi_ip: CTRL, DATA_IN, DATA_OUT and STATUS,
// with START pulse generation, sticky DONE/START_ERR flags and a level interrupt.
module custom_axi_lite_regs
   import custom_axi_ip_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic [DATA_WIDTH-1:0]   ipreg_data_o,
   output logic                    enable_o,
   input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
   input  status_e                 status_i,
   output logic                    irq_o
);

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("custom_axi_lite_regs: DATA_WIDTH must be 32");
   end
   if (ADDR_WIDTH < 4) begin : g_bad_addr_width
      $error("custom_axi_lite_regs: ADDR_WIDTH must be at least 4");
   end

   logic                    wr_req, rd_req;
   logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0]   wr_data, rd_data;
   logic [DATA_WIDTH/8-1:0] wr_strb;
   logic                    wr_err, rd_err;
   logic [1:0]              wr_sel, rd_sel;

   logic                    irq_en;
   logic [DATA_WIDTH-1:0]   data_in, data_out;
   logic                    done_sticky, start_err, prev_done;
   logic                    ctrl_wr, data_in_wr, status_wr_hi;
   logic                    start_req, start_ok, start_rej, done_set, done_clr, err_clr;

   custom_axi_lite_if #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_if (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .s_awaddr  (s_awaddr),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .s_araddr  (s_araddr),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_strb   (wr_strb),
      .wr_err    (wr_err),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_err    (rd_err)
   );

   // Anything above the 16-byte window is unmapped.
   if (ADDR_WIDTH > 4) begin : g_hi_decode
      assign wr_err = |wr_addr[ADDR_WIDTH-1:4];
      assign rd_err = |rd_addr[ADDR_WIDTH-1:4];
   end else begin : g_no_hi_decode
      assign wr_err = 1'b0;
      assign rd_err = 1'b0;
   end

   assign wr_sel = reg_sel(wr_addr[3:0]);
   assign rd_sel = reg_sel(rd_addr[3:0]);

   always_comb begin
      ctrl_wr      = wr_req && !wr_err && (wr_sel == reg_sel(CTRL_OFS))   && wr_strb[0];
      data_in_wr   = wr_req && !wr_err && (wr_sel == reg_sel(DATA_IN_OFS));
      status_wr_hi = wr_req && !wr_err && (wr_sel == reg_sel(STATUS_OFS)) && wr_strb[1];
      start_req    = ctrl_wr && wr_data[START];
      start_ok     = start_req && (status_i == IDLE);
      start_rej    = start_req && (status_i != IDLE);
      done_set     = (status_i == DONE) && !prev_done;
      done_clr     = status_wr_hi && wr_data[DONE_STICKY];
      err_clr      = status_wr_hi && wr_data[START_ERR];
   end

   // Flag updates: a set in the same cycle as a W1C wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_en      <= 1'b0;
         data_in     <= '0;
         data_out    <= '0;
         prev_done   <= 1'b0;
         done_sticky <= 1'b0;
         start_err   <= 1'b0;
         enable_o    <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en <= wr_data[IRQ_EN];
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (data_in_wr && wr_strb[b]) data_in[8*b +: 8] <= wr_data[8*b +: 8];
         end
         if (status_i == DONE) data_out <= ipreg_data_i;
         prev_done   <= (status_i == DONE);
         done_sticky <= done_set  | (done_sticky & ~done_clr);
         start_err   <= start_rej | (start_err & ~err_clr);
         enable_o    <= start_ok;
      end
   end

   always_comb begin
      rd_data = '0;
      if (!rd_err) begin
         case (rd_sel)
            reg_sel(CTRL_OFS):     rd_data[IRQ_EN] = irq_en;
            reg_sel(DATA_IN_OFS):  rd_data = data_in;
            reg_sel(DATA_OUT_OFS): rd_data = data_out;
            default: begin
               rd_data[1:0]        = status_i;
               rd_data[DONE_STICKY] = done_sticky;
               rd_data[START_ERR]   = start_err;
            end
         endcase
      end
   end

   assign ipreg_data_o = data_in;
   assign irq_o        = done_sticky & irq_en;

endmodule

// File: tb/tb_custom_axi_lite_regs.sv
// Directed bench for custom_axi_lite_regs with a response scoreboard and
// immediate-assertion checks.
module tb_custom_axi_lite_regs;
   import custom_axi_ip_pkg::*;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] s_awaddr, s_araddr;
   logic          s_awvalid, s_awready, s_wvalid, s_wready;
   logic [31:0]   s_wdata, s_rdata;
   logic [3:0]    s_wstrb;
   logic [1:0]    s_bresp, s_rresp;
   logic          s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0]   ipreg_data_o, ipreg_data_i;
   logic          enable_o, irq_o;
   status_e       status;

   int n_checks = 0;
   int n_fail   = 0;
   int en_count = 0;
   logic [1:0]  bresp_q[$];
   logic [33:0] rd_q[$];

   custom_axi_lite_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .s_awaddr     (s_awaddr),
      .s_awvalid    (s_awvalid),
      .s_awready    (s_awready),
      .s_wdata      (s_wdata),
      .s_wstrb      (s_wstrb),
      .s_wvalid     (s_wvalid),
      .s_wready     (s_wready),
      .s_bresp      (s_bresp),
      .s_bvalid     (s_bvalid),
      .s_bready     (s_bready),
      .s_araddr     (s_araddr),
      .s_arvalid    (s_arvalid),
      .s_arready    (s_arready),
      .s_rdata      (s_rdata),
      .s_rresp      (s_rresp),
      .s_rvalid     (s_rvalid),
      .s_rready     (s_rready),
      .ipreg_data_o (ipreg_data_o),
      .enable_o     (enable_o),
      .ipreg_data_i (ipreg_data_i),
      .status_i     (status),
      .irq_o        (irq_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (enable_o) en_count++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_lead, input logic [1:0] exp_resp,
                            input bit race_done);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs, found = 0;
      int cyc = 0;
      logic [1:0] exp_b;
      bresp_q.push_back(exp_resp);
      s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_bready = 1'b1;
      s_awvalid = 1'b1; s_wvalid = (aw_lead == 0);
      while (!(aw_done && w_done) && cyc < 50) begin
         @(negedge clk);
         aw_hs = s_awvalid && s_awready;
         w_hs  = s_wvalid && s_wready;
         @(posedge clk); #1;
         if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1; s_wvalid  = 1'b0; end
         cyc++;
         if (!w_done && !s_wvalid && cyc >= aw_lead) s_wvalid = 1'b1;
      end
      check({tag, "_handshake"}, {31'd0, aw_done && w_done}, 32'd1);
      if (race_done) status = DONE;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = s_bvalid;
      end
      check({tag, "_bvalid"}, {31'd0, found}, 32'd1);
      exp_b = bresp_q.pop_front();
      check({tag, "_bresp"}, {30'd0, s_bresp}, {30'd0, exp_b});
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input int hold);
      bit hs = 0, found = 0;
      logic [33:0] exp_r;
      rd_q.push_back({exp_resp, exp_data});
      s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b0;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         hs = s_arvalid && s_arready;
         @(posedge clk); #1;
      end
      s_arvalid = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = s_rvalid;
      end
      check({tag, "_rvalid"}, {31'd0, found}, 32'd1);
      exp_r = rd_q.pop_front();
      check({tag, "_rdata"}, s_rdata, exp_r[31:0]);
      check({tag, "_rresp"}, {30'd0, s_rresp}, {30'd0, exp_r[33:32]});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_rvalid"}, {31'd0, s_rvalid}, 32'd1);
         check({tag, "_hold_rdata"}, s_rdata, exp_r[31:0]);
      end
      @(posedge clk); #1;
      s_rready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0;
   endtask

   initial begin
      int  e0;
      bit  found;
      rst_n = 1'b0;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      ipreg_data_i = '0; status = IDLE;

      // Reset state
      #12;
      check("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
      check("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'd0);
      check("rst_resp_rdata", s_rdata | {28'd0, s_bresp, s_rresp}, 32'd0);
      check("rst_ip_outputs", ipreg_data_o | {30'd0, enable_o, irq_o}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      cycles(2);

      // DATA_IN with AW leading W, byte lanes, ignored low address bits
      axi_write("t1_data_in", 5'h04, 32'h1234_5678, 4'hF, 2, RESP_OKAY, 0);
      check("t1_ipreg", ipreg_data_o, 32'h1234_5678);
      axi_write("t1_lanes", 5'h04, 32'hAABB_CCDD, 4'h5, 0, RESP_OKAY, 0);
      check("t1_lanes_ipreg", ipreg_data_o, 32'h12BB_56DD);
      axi_write("t1_lowbits", 5'h07, 32'h1234_5678, 4'hF, 0, RESP_OKAY, 0);
      axi_read("t1_rd_data_in", 5'h06, 32'h1234_5678, RESP_OKAY, 0);

      // START pulse and a full operation
      ipreg_data_i = 32'h1234_5679;
      e0 = en_count;
      axi_write("t2_start", 5'h00, 32'h1, 4'h1, 0, RESP_OKAY, 0);
      cycles(3);
      check("t2_enable_pulses", en_count - e0, 32'd1);
      status = BUSY; cycles(3);
      status = DONE; cycles(2);
      axi_read("t2_data_out", 5'h08, 32'h1234_5679, RESP_OKAY, 0);
      axi_read("t2_status", 5'h0C, 32'h0000_0102, RESP_OKAY, 0);
      axi_read("t2_ctrl", 5'h00, 32'h0, RESP_OKAY, 0);

      // Interrupt, W1C, and set-vs-clear race
      status = IDLE; cycles(1);
      axi_write("t3_clr", 5'h0C, 32'h100, 4'h2, 0, RESP_OKAY, 0);
      check("t3_irq_low", {31'd0, irq_o}, 32'd0);
      axi_write("t3_start_irq", 5'h00, 32'h3, 4'h1, 0, RESP_OKAY, 0);
      status = BUSY; cycles(2);
      status = DONE; cycles(2);
      check("t3_irq_high", {31'd0, irq_o}, 32'd1);
      axi_write("t3_w1c_lo_strb", 5'h0C, 32'h100, 4'h1, 0, RESP_OKAY, 0);
      check("t3_irq_kept", {31'd0, irq_o}, 32'd1);
      axi_write("t3_w1c", 5'h0C, 32'h100, 4'h2, 0, RESP_OKAY, 0);
      check("t3_irq_cleared", {31'd0, irq_o}, 32'd0);
      axi_read("t3_status_clr", 5'h0C, 32'h0000_0002, RESP_OKAY, 0);
      status = BUSY; cycles(2);
      axi_write("t3_race", 5'h0C, 32'h100, 4'h2, 0, RESP_OKAY, 1);
      axi_read("t3_status_race", 5'h0C, 32'h0000_0102, RESP_OKAY, 0);
      check("t3_irq_race", {31'd0, irq_o}, 32'd1);

      // START while busy
      axi_write("t4_clr", 5'h0C, 32'h100, 4'h2, 0, RESP_OKAY, 0);
      status = BUSY; cycles(1);
      e0 = en_count;
      axi_write("t4_start_busy", 5'h00, 32'h1, 4'h1, 0, RESP_OKAY, 0);
      cycles(3);
      check("t4_no_pulse", en_count - e0, 32'd0);
      axi_read("t4_status_err", 5'h0C, 32'h0000_0201, RESP_OKAY, 0);
      axi_write("t4_w1c_err", 5'h0C, 32'h200, 4'h2, 0, RESP_OKAY, 0);
      axi_read("t4_status_ok", 5'h0C, 32'h0000_0001, RESP_OKAY, 0);

      // Unmapped and read-only accesses, rready back-pressure
      axi_read("t5_rd_unmapped", 5'h10, 32'h0, RESP_SLVERR, 0);
      axi_write("t5_wr_unmapped", 5'h14, 32'hFFFF_FFFF, 4'hF, 0, RESP_SLVERR, 0);
      check("t5_ipreg_kept", ipreg_data_o, 32'h1234_5678);
      axi_read("t5_ctrl_kept", 5'h00, 32'h0, RESP_OKAY, 0);
      axi_write("t5_wr_ro", 5'h08, 32'hDEAD_BEEF, 4'hF, 0, RESP_OKAY, 0);
      axi_read("t5_data_out_kept", 5'h08, 32'h1234_5679, RESP_OKAY, 0);
      axi_read("t5_hold", 5'h04, 32'h1234_5678, RESP_OKAY, 5);

      // Reset during W_RESP with bready low
      s_awaddr = 5'h04; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF; s_bready = 1'b0;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = s_bvalid;
      end
      check("t6_bvalid_before", {31'd0, found}, 32'd1);
      check("t6_written", ipreg_data_o, 32'hCAFE_F00D);
      #2 rst_n = 1'b0;
      #1;
      check("t6_bvalid_reset", {31'd0, s_bvalid}, 32'd0);
      check("t6_regs_reset", ipreg_data_o | {30'd0, enable_o, irq_o}, 32'd0);
      status = IDLE; s_bready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      cycles(2);
      axi_read("t6_ctrl", 5'h00, 32'h0, RESP_OKAY, 0);
      axi_read("t6_data_out", 5'h08, 32'h0, RESP_OKAY, 0);
      axi_read("t6_status", 5'h0C, 32'h0, RESP_OKAY, 0);
      axi_write("t6_first_write", 5'h04, 32'h55AA_55AA, 4'hF, 0, RESP_OKAY, 0);
      check("t6_ipreg", ipreg_data_o, 32'h55AA_55AA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
